// File: rtl/uart_tx_arbiter_pkg.sv
// Shared UART constants and types used by the TX-side arbiter and its helpers.
// Holds the arbiter state encoding, the default line terminator and a counter sizing helper.
package uart_tx_arbiter_pkg;

    localparam int             UART_DATA_WIDTH = 8;
    localparam logic [7:0]     UART_LINE_END   = 8'h0A;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    // Bits needed to hold 0..max_val without wrapping.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side byte channels plus the registered UART TX FIFO channel and owner status.
// master drives requests and out_ready; slave is the arbiter.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8
);
    localparam int ID_WIDTH = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          out_valid;
    logic [DATA_WIDTH-1:0]         out_data;
    logic                          out_ready;
    logic                          owner_valid;
    logic [ID_WIDTH-1:0]           owner_id;

    modport master (
        output req_valid, req_data, out_ready,
        input  req_ready, out_valid, out_data, owner_valid, owner_id
    );

    modport slave (
        input  req_valid, req_data, out_ready,
        output req_ready, out_valid, out_data, owner_valid, owner_id
    );

endinterface

// File: rtl/uart_rr_pick.sv
// Rotating-priority picker: first set request searching cyclically from last_grant+1.
// Purely combinational, no backpressure; found=0 when no request is set.
module uart_rr_pick #(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]  req,
    input  logic [ID_WIDTH-1:0] last_grant,
    output logic                found,
    output logic [ID_WIDTH-1:0] index
);

    int c;

    always_comb begin
        found = 1'b0;
        index = '0;
        c     = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            // last_grant is always < NUM_REQ, so one subtraction wraps it.
            c = int'(last_grant) + k;
            if (c >= NUM_REQ) c = c - NUM_REQ;
            if (!found && req[ID_WIDTH'(c)]) begin
                found = 1'b1;
                index = ID_WIDTH'(c);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin share of the UART TX byte stream, grant locked per message; 1-cycle registered output.
// A requester is ready only when the output slot is empty or draining this cycle.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int                    NUM_REQ      = 4,
    parameter int                    DATA_WIDTH   = UART_DATA_WIDTH,
    parameter int                    MAX_BURST    = 64,
    parameter int                    IDLE_TIMEOUT = 256,
    parameter logic [DATA_WIDTH-1:0] LINE_END     = DATA_WIDTH'(UART_LINE_END),
    localparam int                   ID_WIDTH     = $clog2(NUM_REQ)
) (
    input logic              core_clk,
    input logic              rstn,
    uart_tx_arbiter_if.slave bus
);

    localparam int BURST_W = cnt_width(MAX_BURST);
    localparam int IDLE_W  = cnt_width(IDLE_TIMEOUT);

    arb_state_e            state;
    logic [ID_WIDTH-1:0]   last_grant;
    logic [ID_WIDTH-1:0]   pick_idx;
    logic                  pick_found;
    logic [ID_WIDTH-1:0]   grant_id;
    logic                  grant_en;
    logic                  slot_free;
    logic                  accept;
    logic                  owner_req;
    logic                  is_line_end;
    logic [DATA_WIDTH-1:0] grant_data;
    logic [BURST_W-1:0]    burst_cnt;
    logic [BURST_W-1:0]    burst_nxt;
    logic [IDLE_W-1:0]     idle_cnt;

    uart_rr_pick #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_pick (
        .req        (bus.req_valid),
        .last_grant (last_grant),
        .found      (pick_found),
        .index      (pick_idx)
    );

    assign slot_free   = ~bus.out_valid | bus.out_ready;
    assign grant_id    = (state == ARB_LOCKED) ? bus.owner_id : pick_idx;
    assign grant_en    = (state == ARB_LOCKED) | pick_found;
    assign owner_req   = bus.req_valid[bus.owner_id];
    assign accept      = |(bus.req_valid & bus.req_ready);
    assign is_line_end = (grant_data == LINE_END);
    assign burst_nxt   = burst_cnt + BURST_W'(1);

    always_comb begin
        bus.req_ready = '0;
        grant_data    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id == ID_WIDTH'(i)) begin
                bus.req_ready[i] = grant_en & slot_free;
                grant_data       = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge core_clk or negedge rstn) begin
        if (!rstn) begin
            state           <= ARB_IDLE;
            last_grant      <= ID_WIDTH'(NUM_REQ - 1);
            bus.owner_id    <= '0;
            bus.owner_valid <= 1'b0;
            bus.out_valid   <= 1'b0;
            bus.out_data    <= '0;
            burst_cnt       <= '0;
            idle_cnt        <= '0;
        end else begin
            if (accept) begin
                bus.out_valid <= 1'b1;
                bus.out_data  <= grant_data;
            end else if (bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end

            case (state)
                ARB_IDLE: begin
                    if (accept) begin
                        last_grant   <= pick_idx;
                        bus.owner_id <= pick_idx;
                        // A one-byte message never takes the lock.
                        if (!is_line_end && MAX_BURST != 1) begin
                            state           <= ARB_LOCKED;
                            bus.owner_valid <= 1'b1;
                            burst_cnt       <= BURST_W'(1);
                            idle_cnt        <= '0;
                        end
                    end
                end
                ARB_LOCKED: begin
                    if (accept) begin
                        burst_cnt <= burst_nxt;
                        idle_cnt  <= '0;
                        if (is_line_end || burst_nxt == BURST_W'(MAX_BURST)) begin
                            state           <= ARB_IDLE;
                            bus.owner_valid <= 1'b0;
                            burst_cnt       <= '0;
                        end
                    end else if (!owner_req) begin
                        // Backpressured-but-valid cycles fall through: no aging.
                        if (idle_cnt == IDLE_W'(IDLE_TIMEOUT - 1)) begin
                            state           <= ARB_IDLE;
                            bus.owner_valid <= 1'b0;
                            burst_cnt       <= '0;
                            idle_cnt        <= '0;
                        end else begin
                            idle_cnt <= idle_cnt + IDLE_W'(1);
                        end
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed message scenarios then random traffic, checked against
// a message-level reference model and an output scoreboard.
module tb_uart_tx_arbiter;
    import uart_tx_arbiter_pkg::*;

    localparam int         N    = 4;
    localparam int         DW   = 8;
    localparam int         MAXB = 4;
    localparam int         TO   = 8;
    localparam logic [7:0] LF   = 8'h0A;

    logic core_clk = 1'b0;
    logic rstn     = 1'b0;
    always #5 core_clk = ~core_clk;

    uart_tx_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW)) bus ();

    uart_tx_arbiter #(
        .NUM_REQ      (N),
        .DATA_WIDTH   (DW),
        .MAX_BURST    (MAXB),
        .IDLE_TIMEOUT (TO),
        .LINE_END     (LF)
    ) dut (
        .core_clk (core_clk),
        .rstn     (rstn),
        .bus      (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] src_q [N][$];
    bit         en [N];
    int         rdy_mode;
    logic [7:0] exp_q [$];

    // Reference model: who holds the line, how long the message has run, how long it has been quiet.
    bit         m_locked;
    int         m_owner;
    int         m_last;
    int         m_len;
    int         m_quiet;
    bit         m_ov;
    logic [7:0] m_od;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_clear();
        m_locked = 1'b0;
        m_owner  = 0;
        m_last   = N - 1;
        m_len    = 0;
        m_quiet  = 0;
        m_ov     = 1'b0;
        m_od     = 8'h00;
        exp_q.delete();
        for (int i = 0; i < N; i++) begin
            src_q[i].delete();
            en[i] = 1'b1;
        end
    endtask

    task automatic do_reset();
        rstn          = 1'b0;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.out_ready = 1'b0;
        rdy_mode      = 0;
        model_clear();
        @(posedge core_clk);
        @(posedge core_clk);
        #2;
        chk("rst_out_valid",   bus.out_valid,   0);
        chk("rst_out_data",    bus.out_data,    0);
        chk("rst_owner_valid", bus.owner_valid, 0);
        chk("rst_owner_id",    bus.owner_id,    0);
        chk("rst_req_ready",   bus.req_ready,   0);
        @(negedge core_clk);
        rstn = 1'b1;
        @(posedge core_clk);
        #1;
    endtask

    task automatic drive();
        logic [N-1:0]    v;
        logic [N*DW-1:0] d;
        v = '0;
        d = '0;
        for (int i = 0; i < N; i++) begin
            if (en[i] && src_q[i].size() > 0) begin
                v[i]          = 1'b1;
                d[i*DW +: DW] = src_q[i][0];
            end
        end
        bus.req_valid = v;
        bus.req_data  = d;
        case (rdy_mode)
            0:       bus.out_ready = 1'b1;
            1:       bus.out_ready = 1'b0;
            default: bus.out_ready = ($urandom_range(0, 3) != 0);
        endcase
    endtask

    // One clock: drive at posedge+1, check at negedge, advance the model after the next posedge.
    task automatic step();
        int           g;
        bit           have;
        bit           acc;
        logic [N-1:0] exp_rdy;
        logic [7:0]   b;
        drive();
        have = 1'b0;
        g    = 0;
        b    = 8'h00;
        if (m_locked) begin
            have = 1'b1;
            g    = m_owner;
        end else begin
            for (int k = 1; k <= N; k++) begin
                if (!have && bus.req_valid[(m_last + k) % N]) begin
                    have = 1'b1;
                    g    = (m_last + k) % N;
                end
            end
        end
        exp_rdy = (have && (!m_ov || bus.out_ready)) ? (N'(1) << g) : '0;
        acc     = (exp_rdy & bus.req_valid) != '0;

        @(negedge core_clk);
        chk("req_ready",   bus.req_ready,   exp_rdy);
        chk("out_valid",   bus.out_valid,   m_ov);
        chk("owner_valid", bus.owner_valid, m_locked);
        chk("owner_id",    bus.owner_id,    m_owner);
        if (m_ov) chk("out_data_hold", bus.out_data, m_od);

        @(posedge core_clk);
        #1;
        if (acc) begin
            b = src_q[g].pop_front();
            exp_q.push_back(b);
            m_ov = 1'b1;
            m_od = b;
        end else if (bus.out_ready) begin
            m_ov = 1'b0;
        end
        if (!m_locked) begin
            if (acc) begin
                m_last  = g;
                m_owner = g;
                if (b != LF && MAXB > 1) begin
                    m_locked = 1'b1;
                    m_len    = 1;
                    m_quiet  = 0;
                end
            end
        end else if (acc) begin
            m_len++;
            m_quiet = 0;
            if (b == LF || m_len == MAXB) m_locked = 1'b0;
        end else if (!bus.req_valid[m_owner]) begin
            m_quiet++;
            if (m_quiet == TO) m_locked = 1'b0;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Scoreboard monitor: every delivered byte must be the oldest accepted one.
    initial begin
        forever begin
            @(negedge core_clk);
            if (rstn && bus.out_valid && bus.out_ready) begin
                chk("sb_pending", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) chk("sb_data", bus.out_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        int left;
        do_reset();

        // Single owner, one message.
        src_q[1].push_back(8'h68);
        src_q[1].push_back(8'h69);
        src_q[1].push_back(LF);
        run(6);

        // Two simultaneous messages must not interleave.
        do_reset();
        foreach (src_q[i]) if (i == 0 || i == 2) begin
            src_q[i].push_back(8'h61);
            src_q[i].push_back(8'h62);
            src_q[i].push_back(LF);
        end
        run(10);

        // Burst limit forces release to a waiting requester.
        do_reset();
        for (int i = 0; i < 10; i++) src_q[3].push_back(8'h41 + 8'(i));
        step();
        src_q[0].push_back(8'h7A);
        src_q[0].push_back(LF);
        run(24);

        // Idle timeout hands the line to the pending requester.
        do_reset();
        src_q[2].push_back(8'h78);
        step();
        src_q[1].push_back(8'h6B);
        src_q[1].push_back(LF);
        run(16);

        // Long backpressure inside a lock: data held, no timeout, one byte per ready pulse.
        do_reset();
        src_q[1].push_back(8'h70);
        src_q[1].push_back(8'h71);
        src_q[1].push_back(8'h72);
        src_q[1].push_back(LF);
        step();
        src_q[2].push_back(8'h77);
        src_q[2].push_back(LF);
        rdy_mode = 1;
        run(20);
        for (int i = 0; i < 3; i++) begin
            rdy_mode = 0;
            step();
            rdy_mode = 1;
            run(3);
        end
        rdy_mode = 0;
        run(8);

        // Asynchronous reset between edges while locked.
        do_reset();
        src_q[3].push_back(8'h6D);
        src_q[3].push_back(8'h6E);
        src_q[3].push_back(8'h6F);
        run(2);
        #2 rstn = 1'b0;
        #1;
        chk("async_out_valid",   bus.out_valid,   0);
        chk("async_owner_valid", bus.owner_valid, 0);
        do_reset();
        src_q[0].push_back(8'h30);
        src_q[0].push_back(LF);
        src_q[1].push_back(8'h31);
        src_q[1].push_back(LF);
        run(8);

        // Random traffic with valid toggling and random backpressure.
        do_reset();
        rdy_mode = 2;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (src_q[i].size() < 3 && $urandom_range(0, 3) == 0)
                    src_q[i].push_back(($urandom_range(0, 4) == 0) ? LF : 8'($urandom_range(32, 126)));
                en[i] = ($urandom_range(0, 9) != 0);
            end
            step();
        end
        for (int i = 0; i < N; i++) en[i] = 1'b1;
        rdy_mode = 0;
        run(80);

        left = 0;
        for (int i = 0; i < N; i++) left += src_q[i].size();
        chk("src_drained", left, 0);
        chk("sb_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
